// File: rtl/aes_pkg.sv
// Shared AES constants and the serializer state encoding.
package aes_pkg;

  localparam int AES_BLOCK_W     = 128;
  localparam int AES_BYTE_W      = 8;
  localparam int AES_BLOCK_BYTES = 16;
  localparam int IDX_W           = $clog2(AES_BLOCK_BYTES);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(AES_BLOCK_BYTES - 1);

  typedef enum logic [1:0] {
    EMPTY,
    SEND,
    SEND_PEND
  } ser_state_t;

endpackage

// File: rtl/taxi_axis_if.sv
// Minimal AXI-Stream bundle with source and sink views.
interface taxi_axis_if #(
  parameter int DATA_W = 8,
  parameter int KEEP_W = (DATA_W + 7) / 8,
  parameter int ID_W   = 8,
  parameter int DEST_W = 8,
  parameter int USER_W = 8
) ();

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic [KEEP_W-1:0] tstrb;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [ID_W-1:0]   tid;
  logic [DEST_W-1:0] tdest;
  logic [USER_W-1:0] tuser;

  modport src (
    output tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
    input  tready
  );

  modport snk (
    input  tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
    output tready
  );

endinterface

// File: rtl/aes_block_serializer.sv
// 128-bit block to MSB-first byte stream converter with a one-block pending
// slot so a new block can be taken while the current one drains.
module aes_block_serializer
  import aes_pkg::*;
#(
  parameter bit LAST_EVERY_BLOCK = 1'b1,
  parameter int ID_W             = 8,
  parameter int DEST_W           = 8,
  parameter int USER_W           = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       En,
  taxi_axis_if.snk   s_axis,
  taxi_axis_if.src   m_axis,
  output ser_state_t dbg_state
);

  // Handshakes: a transfer happens on a rising edge where tvalid && tready.
  // A source never drops tvalid or changes its payload until that edge;
  // s_axis.tready depends on state and En only, never on m_axis.tready.

  ser_state_t state, state_nxt;
  logic [IDX_W-1:0] idx;

  logic [AES_BLOCK_W-1:0] a_data, p_data;
  logic                   a_last, p_last;
  logic [ID_W-1:0]        a_id, p_id;
  logic [DEST_W-1:0]      a_dest, p_dest;
  logic [USER_W-1:0]      a_user, p_user;

  logic sink_ready;
  logic out_valid;
  logic blk_hs;
  logic byte_hs;
  logic last_hs;
  logic load_a_s;
  logic load_a_p;
  logic load_p;

  assign sink_ready = En && !Rst && (state != SEND_PEND);
  assign out_valid  = (state != EMPTY);
  assign blk_hs     = s_axis.tvalid && sink_ready;
  assign byte_hs    = out_valid && m_axis.tready;
  assign last_hs    = byte_hs && (idx == IDX_LAST);

  always_comb begin
    state_nxt = state;
    load_a_s  = 1'b0;
    load_a_p  = 1'b0;
    load_p    = 1'b0;
    case (state)
      EMPTY: begin
        if (blk_hs) begin
          state_nxt = SEND;
          load_a_s  = 1'b1;
        end
      end
      SEND: begin
        // A block arriving with the final byte goes straight into A: no bubble.
        if (blk_hs && last_hs) begin
          load_a_s = 1'b1;
        end else if (blk_hs) begin
          state_nxt = SEND_PEND;
          load_p    = 1'b1;
        end else if (last_hs) begin
          state_nxt = EMPTY;
        end
      end
      SEND_PEND: begin
        if (last_hs) begin
          state_nxt = SEND;
          load_a_p  = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= EMPTY;
      idx    <= '0;
      a_data <= '0;
      a_last <= 1'b0;
      a_id   <= '0;
      a_dest <= '0;
      a_user <= '0;
      p_data <= '0;
      p_last <= 1'b0;
      p_id   <= '0;
      p_dest <= '0;
      p_user <= '0;
    end else begin
      state <= state_nxt;

      if (load_a_s || load_a_p) begin
        idx <= '0;
      end else if (byte_hs) begin
        idx <= idx + 1'b1;
      end

      if (load_a_s) begin
        a_data <= s_axis.tdata;
        a_last <= s_axis.tlast;
        a_id   <= s_axis.tid;
        a_dest <= s_axis.tdest;
        a_user <= s_axis.tuser;
      end else if (load_a_p) begin
        a_data <= p_data;
        a_last <= p_last;
        a_id   <= p_id;
        a_dest <= p_dest;
        a_user <= p_user;
      end

      if (load_p) begin
        p_data <= s_axis.tdata;
        p_last <= s_axis.tlast;
        p_id   <= s_axis.tid;
        p_dest <= s_axis.tdest;
        p_user <= s_axis.tuser;
      end
    end
  end

  assign s_axis.tready = sink_ready;

  // Byte 0 is the most significant byte of the block.
  assign m_axis.tdata  = a_data[(AES_BLOCK_BYTES - 1 - int'(idx)) * AES_BYTE_W +: AES_BYTE_W];
  assign m_axis.tvalid = out_valid;
  assign m_axis.tlast  = (idx == IDX_LAST) && (LAST_EVERY_BLOCK || a_last);
  assign m_axis.tid    = a_id;
  assign m_axis.tdest  = a_dest;
  assign m_axis.tuser  = a_user;
  assign m_axis.tkeep  = out_valid ? '1 : '0;
  assign m_axis.tstrb  = out_valid ? '1 : '0;

  assign dbg_state = state;

endmodule
